// File: rtl/dot_matrix_scroller.sv
// Column-multiplexed LED dot-matrix scroller with a writable pattern memory.
// Optional build macro DOTMAT_BLANKING_EN blanks row for BLANK_CYC cycles after each column switch.
module dot_matrix_scroller #(
  parameter int COLS       = 5,
  parameter int ROWS       = 7,
  parameter int MSG_LEN    = 50,
  parameter int SCAN_DIV   = 5400,
  parameter int STEP_TICKS = 5000,
  parameter int POS_W      = 8,
  parameter int BLANK_CYC  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             wr_en,
  input  logic [POS_W-1:0] wr_addr,
  input  logic [ROWS-1:0]  wr_data,
  output logic [1:0]       portA,
  output logic [1:0]       portB,
  output logic [COLS-1:0]  col,
  output logic [ROWS-1:0]  row,
  output logic [POS_W-1:0] pos
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int IDX_W  = POS_W + 1;
  localparam int MEM_AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [IDX_W-1:0]  LEN_W     = IDX_W'(MSG_LEN);

  if (MSG_LEN < COLS) begin : g_bad_len
    $error("dot_matrix_scroller: MSG_LEN must be >= COLS");
  end
  if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
    $error("dot_matrix_scroller: BLANK_CYC must be < SCAN_DIV");
  end

  logic [ROWS-1:0]   mem [MSG_LEN];
  logic [SCAN_W-1:0] scan_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              scan_tick;
  logic              step_tick;
  logic [COLS-1:0]   col_rot;
  logic [COLS-1:0]   col_low;
  logic              one_low;
  logic [IDX_W-1:0]  col_idx;
  logic [IDX_W-1:0]  rd_sum;
  logic [IDX_W-1:0]  rd_addr;
  logic [IDX_W-1:0]  step_sz;
  logic [IDX_W-1:0]  pos_raw;
  logic [IDX_W-1:0]  pos_wrap;

  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign step_tick = scan_tick & en & (step_cnt == STEP_LAST);

  // Low bit walks upward; the top column hands over to column 0.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_rot
    assign col_rot[gi] = col[(gi + COLS - 1) % COLS];
  end

  assign col_low = ~col;
  assign one_low = (col_low != '0) && ((col_low & (col_low - COLS'(1))) == '0);

  always_comb begin
    col_idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!col[i]) col_idx = IDX_W'(i);
    end
  end

  // pos < MSG_LEN and col_idx < COLS <= MSG_LEN, so one subtraction wraps.
  assign rd_sum  = {1'b0, pos} + col_idx;
  assign rd_addr = (rd_sum >= LEN_W) ? (rd_sum - LEN_W) : rd_sum;

  assign step_sz  = mode ? IDX_W'(COLS) : IDX_W'(1);
  assign pos_raw  = dir ? ({1'b0, pos} + LEN_W - step_sz) : ({1'b0, pos} + step_sz);
  assign pos_wrap = (pos_raw >= LEN_W) ? (pos_raw - LEN_W) : pos_raw;

  always_comb begin
    row = '0;
    if (one_low) row = mem[MEM_AW'(rd_addr)];
`ifdef DOTMAT_BLANKING_EN
    if (scan_cnt < SCAN_W'(BLANK_CYC)) row = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      portA    <= 2'b00;
      portB    <= 2'b00;
      col      <= '1;
      pos      <= '0;
      scan_cnt <= '0;
      step_cnt <= '0;
    end else begin
      portA    <= 2'b01;
      portB    <= 2'b01;
      scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_tick) begin
        col <= (&col) ? ~COLS'(1) : col_rot;
        if (en) step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_W'(1);
      end
      if (step_tick) pos <= POS_W'(pos_wrap);
    end
  end

  // Pattern memory has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (reset && wr_en && ({1'b0, wr_addr} < LEN_W)) mem[MEM_AW'(wr_addr)] <= wr_data;
  end

endmodule
